// File: rtl/axi_pkg.sv
// Shared types for the AXI-Lite slave write path: response codes and join FSM states.
package axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } join_state_t;

endpackage

// File: rtl/axi_hold_reg.sv
// One-deep holding register with full flag: loads on handshake, empties on clear.
// Latency: captured value visible the cycle after load.
// Backpressure: owner derives READY from !full; clear wins over load.
module axi_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            full <= 1'b0;
            q    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            q    <= d;
        end
    end

endmodule

// File: rtl/axi_write_join.sv
// AXI-Lite AW/W join: pairs one address and one data beat into one strobed memory write plus B response.
// Latency: both beats in cycle 0 -> MEM_WE in cycle 1, BVALID in cycle 2.
// Backpressure: READY = !full per channel; MEM_BUSY stalls the write, BREADY stalls the response and both channels.
module axi_write_join
    import axi_pkg::*;
#(
    parameter int LEN_ADDR = 10,
    parameter int LEN_DATA = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [LEN_ADDR:0]     AWADDR,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic [LEN_DATA-1:0]   WDATA,
    input  logic [LEN_DATA/8-1:0] WSTRB,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [1:0]            BRESP,
    output logic                  MEM_WE,
    output logic [LEN_ADDR-1:0]   MEM_ADDR,
    output logic [LEN_DATA-1:0]   MEM_DATA,
    output logic [LEN_DATA/8-1:0] MEM_STRB,
    input  logic                  MEM_BUSY
);

    localparam int STRB_W = LEN_DATA / 8;
    localparam int W_W    = LEN_DATA + STRB_W;

    join_state_t           state;
    resp_t                 bresp;

    logic                  aw_full;
    logic                  w_full;
    logic                  aw_load;
    logic                  w_load;
    logic                  pair_clr;
    logic [LEN_ADDR:0]     aw_q;
    logic [W_W-1:0]        w_q;
    logic [STRB_W-1:0]     w_strb;
    logic                  chip_sel;
    logic                  strb_nz;
    logic                  pair_rdy;

    // READY comes only from the registered flags, so no VALID or BREADY path reaches it.
    assign AWREADY  = !aw_full && !ARESET;
    assign WREADY   = !w_full  && !ARESET;
    assign aw_load  = AWVALID && AWREADY;
    assign w_load   = WVALID  && WREADY;
    assign pair_clr = BVALID  && BREADY;

    axi_hold_reg #(.WIDTH(LEN_ADDR + 1)) u_aw_hold (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .load   (aw_load),
        .clear  (pair_clr),
        .d      (AWADDR),
        .q      (aw_q),
        .full   (aw_full)
    );

    axi_hold_reg #(.WIDTH(W_W)) u_w_hold (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .load   (w_load),
        .clear  (pair_clr),
        .d      ({WDATA, WSTRB}),
        .q      (w_q),
        .full   (w_full)
    );

    assign w_strb   = w_q[STRB_W-1:0];
    assign chip_sel = aw_q[LEN_ADDR];
    assign strb_nz  = |w_strb;
    // Look ahead at this cycle's loads so the write lands the cycle after the second beat.
    assign pair_rdy = (aw_full || aw_load) && (w_full || w_load);

    assign MEM_ADDR = aw_q[LEN_ADDR-1:0];
    assign MEM_DATA = w_q[W_W-1:STRB_W];
    assign MEM_STRB = w_strb;
    assign MEM_WE   = (state == WRITE) && !ARESET && chip_sel && strb_nz && !MEM_BUSY;

    assign BVALID   = (state == RESP) && !ARESET;
    assign BRESP    = bresp;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
            bresp <= OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (pair_rdy) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (!chip_sel) begin
                        bresp <= DECERR;
                        state <= RESP;
                    end else if (!strb_nz || !MEM_BUSY) begin
                        bresp <= OKAY;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (BREADY) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_join.sv
// Directed self-checking bench for axi_write_join: latency, ordering, decode error, stalls and reset abort.
module tb_axi_write_join;

    logic        ACLK;
    logic        ARESET;
    logic        AWVALID;
    logic        AWREADY;
    logic [10:0] AWADDR;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic        MEM_WE;
    logic [9:0]  MEM_ADDR;
    logic [31:0] MEM_DATA;
    logic [3:0]  MEM_STRB;
    logic        MEM_BUSY;

    int n_chk  = 0;
    int n_fail = 0;
    int we_cnt = 0;

    axi_write_join #(.LEN_ADDR(10), .LEN_DATA(32)) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .AWADDR   (AWADDR),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .BRESP    (BRESP),
        .MEM_WE   (MEM_WE),
        .MEM_ADDR (MEM_ADDR),
        .MEM_DATA (MEM_DATA),
        .MEM_STRB (MEM_STRB),
        .MEM_BUSY (MEM_BUSY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) if (MEM_WE === 1'b1) we_cnt++;

    task automatic cyc;
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset;
        ARESET = 1'b1;
        @(negedge ACLK);
        n_chk++; if (AWREADY !== 1'b0) begin n_fail++; $display("FAIL rst_awready got %b want 0", AWREADY); end
        n_chk++; if (WREADY !== 1'b0) begin n_fail++; $display("FAIL rst_wready got %b want 0", WREADY); end
        n_chk++; if (BVALID !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid got %b want 0", BVALID); end
        n_chk++; if (BRESP !== 2'b00) begin n_fail++; $display("FAIL rst_bresp got %b want 00", BRESP); end
        n_chk++; if (MEM_WE !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %b want 0", MEM_WE); end
        cyc();
        ARESET = 1'b0;
        @(negedge ACLK);
        n_chk++; if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %b%b want 11", AWREADY, WREADY); end
        n_chk++; if (MEM_ADDR !== 10'h0 || MEM_DATA !== 32'h0 || MEM_STRB !== 4'h0) begin
            n_fail++; $display("FAIL post_rst_mem got %h/%h/%h want 0/0/0", MEM_ADDR, MEM_DATA, MEM_STRB); end
        cyc();
    endtask

    task automatic test_same_cycle;
        int w0 = we_cnt;
        AWVALID = 1'b1; AWADDR = 11'h405; WVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; BREADY = 1'b1;
        @(negedge ACLK);
        n_chk++; if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin n_fail++; $display("FAIL sc_ready got %b%b want 11", AWREADY, WREADY); end
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK);
        n_chk++; if (MEM_WE !== 1'b1) begin n_fail++; $display("FAIL sc_we got %b want 1", MEM_WE); end
        n_chk++; if (MEM_ADDR !== 10'h005) begin n_fail++; $display("FAIL sc_addr got %h want 005", MEM_ADDR); end
        n_chk++; if (MEM_DATA !== 32'hDEADBEEF || MEM_STRB !== 4'hF) begin n_fail++; $display("FAIL sc_data got %h/%h want deadbeef/f", MEM_DATA, MEM_STRB); end
        n_chk++; if (BVALID !== 1'b0 || AWREADY !== 1'b0) begin n_fail++; $display("FAIL sc_c1_bv_awr got %b%b want 00", BVALID, AWREADY); end
        cyc();
        @(negedge ACLK);
        n_chk++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin n_fail++; $display("FAIL sc_b got %b/%b want 1/00", BVALID, BRESP); end
        n_chk++; if (MEM_WE !== 1'b0) begin n_fail++; $display("FAIL sc_we_c2 got %b want 0", MEM_WE); end
        cyc();
        @(negedge ACLK);
        n_chk++; if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin
            n_fail++; $display("FAIL sc_c3 got bv=%b awr=%b wr=%b want 0 1 1", BVALID, AWREADY, WREADY); end
        n_chk++; if (we_cnt - w0 !== 1) begin n_fail++; $display("FAIL sc_we_count got %0d want 1", we_cnt - w0); end
        cyc();
    endtask

    task automatic test_w_first;
        int w0 = we_cnt;
        WVALID = 1'b1; WDATA = 32'h11223344; WSTRB = 4'h3;
        cyc();
        WVALID = 1'b0;
        @(negedge ACLK);
        n_chk++; if (WREADY !== 1'b0 || AWREADY !== 1'b1) begin n_fail++; $display("FAIL wf_ready got w=%b aw=%b want 0 1", WREADY, AWREADY); end
        cyc();
        @(negedge ACLK);
        n_chk++; if (MEM_WE !== 1'b0) begin n_fail++; $display("FAIL wf_early_we got %b want 0", MEM_WE); end
        cyc();
        AWVALID = 1'b1; AWADDR = 11'h410;
        @(negedge ACLK);
        n_chk++; if (MEM_WE !== 1'b0) begin n_fail++; $display("FAIL wf_we_at_aw got %b want 0", MEM_WE); end
        cyc();
        AWVALID = 1'b0;
        @(negedge ACLK);
        n_chk++; if (MEM_WE !== 1'b1 || MEM_ADDR !== 10'h010) begin n_fail++; $display("FAIL wf_we got %b/%h want 1/010", MEM_WE, MEM_ADDR); end
        n_chk++; if (MEM_DATA !== 32'h11223344 || MEM_STRB !== 4'h3) begin n_fail++; $display("FAIL wf_data got %h/%h want 11223344/3", MEM_DATA, MEM_STRB); end
        cyc();
        @(negedge ACLK);
        n_chk++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin n_fail++; $display("FAIL wf_b got %b/%b want 1/00", BVALID, BRESP); end
        cyc();
        @(negedge ACLK);
        n_chk++; if (we_cnt - w0 !== 1) begin n_fail++; $display("FAIL wf_we_count got %0d want 1", we_cnt - w0); end
        cyc();
    endtask

    task automatic test_decerr;
        int w0 = we_cnt;
        AWVALID = 1'b1; AWADDR = 11'h005; WVALID = 1'b1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF;
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK);
        n_chk++; if (MEM_WE !== 1'b0) begin n_fail++; $display("FAIL de_we got %b want 0", MEM_WE); end
        cyc();
        @(negedge ACLK);
        n_chk++; if (BVALID !== 1'b1 || BRESP !== 2'b11) begin n_fail++; $display("FAIL de_b got %b/%b want 1/11", BVALID, BRESP); end
        cyc();
        @(negedge ACLK);
        n_chk++; if (BVALID !== 1'b0 || we_cnt - w0 !== 0) begin n_fail++; $display("FAIL de_after got bv=%b we=%0d want 0 0", BVALID, we_cnt - w0); end
        cyc();
    endtask

    task automatic test_busy_bready;
        int w0 = we_cnt;
        MEM_BUSY = 1'b1; BREADY = 1'b0;
        AWVALID = 1'b1; AWADDR = 11'h7FF; WVALID = 1'b1; WDATA = 32'h0BADCAFE; WSTRB = 4'hC;
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge ACLK);
            n_chk++; if (MEM_WE !== 1'b0 || BVALID !== 1'b0) begin n_fail++; $display("FAIL busy_stall%0d got we=%b bv=%b want 0 0", i, MEM_WE, BVALID); end
            cyc();
        end
        MEM_BUSY = 1'b0;
        @(negedge ACLK);
        n_chk++; if (MEM_WE !== 1'b1 || MEM_ADDR !== 10'h3FF || MEM_STRB !== 4'hC) begin
            n_fail++; $display("FAIL busy_we got %b/%h/%h want 1/3ff/c", MEM_WE, MEM_ADDR, MEM_STRB); end
        cyc();
        AWVALID = 1'b1; AWADDR = 11'h4AA;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            n_chk++; if (BVALID !== 1'b1 || BRESP !== 2'b00 || AWREADY !== 1'b0) begin
                n_fail++; $display("FAIL bhold%0d got bv=%b br=%b awr=%b want 1 00 0", i, BVALID, BRESP, AWREADY); end
            cyc();
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        n_chk++; if (BVALID !== 1'b1) begin n_fail++; $display("FAIL bhold_release got %b want 1", BVALID); end
        cyc();
        WVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'h0;
        @(negedge ACLK);
        n_chk++; if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin n_fail++; $display("FAIL bhold_after got bv=%b awr=%b want 0 1", BVALID, AWREADY); end
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK);
        n_chk++; if (MEM_WE !== 1'b0) begin n_fail++; $display("FAIL zstrb_we got %b want 0", MEM_WE); end
        cyc();
        @(negedge ACLK);
        n_chk++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin n_fail++; $display("FAIL zstrb_b got %b/%b want 1/00", BVALID, BRESP); end
        cyc();
        @(negedge ACLK);
        n_chk++; if (we_cnt - w0 !== 1) begin n_fail++; $display("FAIL busy_we_count got %0d want 1", we_cnt - w0); end
        cyc();
    endtask

    task automatic test_reset_abort;
        int w0 = we_cnt;
        MEM_BUSY = 1'b1; BREADY = 1'b1;
        AWVALID = 1'b1; AWADDR = 11'h401; WVALID = 1'b1; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF;
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK);
        n_chk++; if (MEM_WE !== 1'b0) begin n_fail++; $display("FAIL ab_busy_we got %b want 0", MEM_WE); end
        cyc();
        ARESET = 1'b1; MEM_BUSY = 1'b0;
        @(negedge ACLK);
        n_chk++; if (MEM_WE !== 1'b0 || BVALID !== 1'b0) begin n_fail++; $display("FAIL ab_rst_cycle got we=%b bv=%b want 0 0", MEM_WE, BVALID); end
        cyc();
        ARESET = 1'b0;
        @(negedge ACLK);
        n_chk++; if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin n_fail++; $display("FAIL ab_ready got %b%b want 11", AWREADY, WREADY); end
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            n_chk++; if (BVALID !== 1'b0 || MEM_WE !== 1'b0) begin n_fail++; $display("FAIL ab_quiet%0d got bv=%b we=%b want 0 0", i, BVALID, MEM_WE); end
            cyc();
        end
        n_chk++; if (we_cnt - w0 !== 0) begin n_fail++; $display("FAIL ab_we_count got %0d want 0", we_cnt - w0); end
    endtask

    task automatic test_back_to_back;
        logic [10:0] addrs [3];
        logic [9:0]  exp_a [3];
        int w0 = we_cnt;
        addrs[0] = 11'h400; addrs[1] = 11'h5A5; addrs[2] = 11'h7FE;
        exp_a[0] = 10'h000; exp_a[1] = 10'h1A5; exp_a[2] = 10'h3FE;
        BREADY = 1'b1;
        for (int t = 0; t < 3; t++) begin
            AWVALID = 1'b1; AWADDR = addrs[t]; WVALID = 1'b1; WDATA = 32'hA0A0_0000 + t; WSTRB = 4'h1;
            cyc();
            AWVALID = 1'b0; WVALID = 1'b0;
            @(negedge ACLK);
            n_chk++; if (MEM_WE !== 1'b1 || MEM_ADDR !== exp_a[t] || MEM_DATA !== 32'hA0A0_0000 + t) begin
                n_fail++; $display("FAIL b2b_we%0d got %b/%h/%h want 1/%h/%h", t, MEM_WE, MEM_ADDR, MEM_DATA, exp_a[t], 32'hA0A0_0000 + t); end
            cyc();
            @(negedge ACLK);
            n_chk++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin n_fail++; $display("FAIL b2b_b%0d got %b/%b want 1/00", t, BVALID, BRESP); end
            cyc();
        end
        @(negedge ACLK);
        n_chk++; if (we_cnt - w0 !== 3) begin n_fail++; $display("FAIL b2b_we_count got %0d want 3", we_cnt - w0); end
        cyc();
    endtask

    initial begin
        ARESET = 1'b1; AWVALID = 1'b0; AWADDR = '0; WVALID = 1'b0; WDATA = '0; WSTRB = '0;
        BREADY = 1'b1; MEM_BUSY = 1'b0;
        test_reset();
        test_same_cycle();
        test_w_first();
        test_decerr();
        test_busy_bready();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
